fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage sitting directly downstream of the program counter register. It takes the current `pc`, performs a request/acknowledge read of instruction memory, and latches the returned word into the instruction register for the decoder. It returns `pc_plus_1` and a one-cycle `pc_step` advance strobe to the PC. On a taken branch it flushes its contents, including any fetch still in flight.

## Interface
- `AW`, 8: address / PC width
- `IW`, 16: instruction width

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `pc`  in  AW  current PC from the PC register
- `fetch_en`  in  1  allow new fetches
- `br_taken`  in  1  redirect; flush IR and any in-flight fetch
- `imem_req`  out  1  memory read request (registered)
- `imem_addr`  out  AW  read address (registered; stable while `imem_req`=1)
- `imem_ack`  in  1  memory read data valid
- `imem_rdata`  in  IW  read data, sampled when `imem_req`&`imem_ack`
- `ir`  out  IW  instruction register
- `ir_pc`  out  AW  address `ir` was fetched from
- `ir_valid`  out  1  `ir` holds a live instruction
- `de_ready`  in  1  decoder accepts `ir` this cycle
- `pc_plus_1`  out  AW  `ir_pc`+1, modulo 2^AW
- `pc_step`  out  1  one-cycle strobe: PC loads `pc_plus_1`

## Operation
- FSM states: IDLE, REQ, FULL, DROP.
- Reset (`rst`=0, asynchronous): state=IDLE. `imem_req`=0, `imem_addr`=0, `ir`=0, `ir_pc`=0, `ir_valid`=0, `pc_plus_1`=1, `pc_step`=0.
- IDLE: if `fetch_en`&!`br_taken`, go to REQ. Latch `imem_addr`←`pc` and set `imem_req`=1.
- REQ: hold `imem_req`=1 with `imem_addr` stable until ack.
  - On `imem_ack`&!`br_taken`: `ir`←`imem_rdata`, `ir_pc`←`imem_addr`, `pc_plus_1`←`imem_addr`+1, `ir_valid`←1, `pc_step`←1 for one cycle, `imem_req`←0, go to FULL.
  - On `br_taken`&!`imem_ack`: go to DROP. The request stays asserted because memory cannot abort.
  - On `br_taken`&`imem_ack`: discard the data and go to IDLE.
- FULL: holds `ir` until handoff (`ir_valid`&`de_ready`).
  - On handoff with `fetch_en`: issue the next request in the same edge (`imem_addr`←`pc`, go to REQ). `ir_valid` drops.
  - On handoff without `fetch_en`: go to IDLE.
  - No handoff: `ir`, `ir_pc`, `ir_valid` unchanged.
- DROP: keep `imem_req`=1 until `imem_ack`. Discard the data, set `imem_req`←0, go to IDLE. No `pc_step`. Further `br_taken` is ignored.
- `br_taken` has priority over handoff and ack in every state:
  - `ir_valid`←0 on the next edge.
  - `pc_step` is never asserted in the cycle after `br_taken`; the PC loads the branch target X instead.
- `fetch_en`=0 does not cancel an outstanding request. It only blocks new issues.
- Address arithmetic wraps: `ir_pc`=FF gives `pc_plus_1`=00.

## Timing
- Handshake: a transfer completes on an edge where `imem_req`=1 and `imem_ack`=1. Ack is legal in the first request cycle (zero wait).
- Latency:
  - Edge E0: IDLE→REQ, request rises.
  - Zero-wait ack in the cycle after E0: at edge E1, `ir_valid`=1 and `pc_step`=1.
  - Each memory wait cycle adds one cycle.
- Throughput: with a zero-wait memory and `de_ready`=1, one instruction every 2 cycles.
- `pc` must reflect the PC update one edge after `pc_step`. It is sampled at the next issue.
- Reset asserted mid-fetch or in DROP: all outputs go to reset values immediately. Any later `imem_ack` is ignored.

## Structure
- Shared package `cpu_pkg`: `AW`, `IW` defaults, the fetch-state enum (IDLE/REQ/FULL/DROP), and the reset PC value 0.
- No sub-module required. An optional `ir_reg` holding `ir`/`ir_pc`/`ir_valid` is acceptable; keep the FSM in `fetch_stage`.

## Test plan
- Reset mid-REQ with `imem_addr`=05 → all outputs at reset values the same cycle. A later `imem_ack` produces no `ir_valid`.
- `pc`=00, zero-wait memory returning 0x1234, `de_ready`=1 → `ir`=1234, `ir_pc`=00, `pc_plus_1`=01, `pc_step` high for 1 cycle. Next request issued at 01.
- Memory with 3 wait cycles → `imem_addr` stable for all 4 request cycles. `ir_valid` arrives 4 cycles after the request rises.
- `br_taken` in REQ at addr 10, ack 2 cycles later with 0xDEAD → DROP state, `ir_valid` stays 0, no `pc_step`. The next fetch uses the new `pc`=40.
- `de_ready`=0 for 5 cycles in FULL with 0xBEEF → `ir` holds BEEF and no new request is issued. Handoff on `de_ready`=1, then a request at the stepped `pc`.
- `pc`=FF fetch → `pc_plus_1`=00. Simultaneous handoff and `br_taken` → `br_taken` wins, no `pc_step`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, fetch FSM states, reset PC.
package cpu_pkg;

  localparam int CPU_AW = 8;
  localparam int CPU_IW = 16;

  localparam logic [CPU_AW-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus: fetch stage is master, memory is slave.
interface fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int IW = CPU_IW
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: req/ack read of imem into the IR, PC step strobe, branch flush.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int IW = CPU_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          fetch_en,
  input  logic          br_taken,
  fetch_stage_if.master imem,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          de_ready,
  output logic [AW-1:0] pc_plus_1,
  output logic          pc_step
);

  fetch_state_e  state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic [AW-1:0] pp1_q, pp1_d;
  logic          irv_q, irv_d;
  logic          step_q, step_d;

  logic ack, handoff;
  assign ack     = req_q & imem.imem_ack;
  assign handoff = irv_q & de_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: branch outranks ack and handoff; DROP waits out the memory
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_en && !br_taken) state_d = REQ;
      REQ: begin
        if (br_taken)  state_d = ack ? IDLE : DROP;
        else if (ack)  state_d = FULL;
      end
      FULL: begin
        if (br_taken)     state_d = IDLE;
        else if (handoff) state_d = fetch_en ? REQ : IDLE;
      end
      DROP: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; pc_step is a single-cycle pulse
  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    pp1_d   = pp1_q;
    irv_d   = irv_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en && !br_taken) begin
          req_d  = 1'b1;
          addr_d = pc;
        end
      end
      REQ: begin
        if (br_taken) begin
          // memory cannot abort: keep requesting unless it just acked
          if (ack) req_d = 1'b0;
        end else if (ack) begin
          ir_d    = imem.imem_rdata;
          ir_pc_d = addr_q;
          pp1_d   = addr_q + AW'(1);
          irv_d   = 1'b1;
          step_d  = 1'b1;
          req_d   = 1'b0;
        end
      end
      FULL: begin
        if (!br_taken && handoff) begin
          irv_d = 1'b0;
          if (fetch_en) begin
            req_d  = 1'b1;
            addr_d = pc;
          end
        end
      end
      DROP: if (ack) req_d = 1'b0;
      default: ;
    endcase
    if (br_taken) irv_d = 1'b0;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      addr_q  <= AW'(RESET_PC);
      ir_q    <= '0;
      ir_pc_q <= AW'(RESET_PC);
      pp1_q   <= AW'(RESET_PC) + AW'(1);
      irv_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      pp1_q   <= pp1_d;
      irv_q   <= irv_d;
      step_q  <= step_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign ir             = ir_q;
  assign ir_pc          = ir_pc_q;
  assign ir_valid       = irv_q;
  assign pc_plus_1      = pp1_q;
  assign pc_step        = step_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait, wait states, branch flush, stall, wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pc = '0;
  logic        fetch_en = 1'b0;
  logic        br_taken = 1'b0;
  logic        de_ready = 1'b0;
  logic [15:0] ir;
  logic [7:0]  ir_pc, pc_plus_1;
  logic        ir_valid, pc_step;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage_if #(.AW(8), .IW(16)) bus ();

  fetch_stage #(.AW(8), .IW(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .br_taken(br_taken),
    .imem(bus), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .de_ready(de_ready), .pc_plus_1(pc_plus_1), .pc_step(pc_step)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},   32'(bus.imem_req),  32'h0);
    chk({tag, ".addr"},  32'(bus.imem_addr), 32'h0);
    chk({tag, ".ir"},    32'(ir),            32'h0);
    chk({tag, ".ir_pc"}, 32'(ir_pc),         32'h0);
    chk({tag, ".irv"},   32'(ir_valid),      32'h0);
    chk({tag, ".pp1"},   32'(pc_plus_1),     32'h1);
    chk({tag, ".step"},  32'(pc_step),       32'h0);
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    // power-on reset
    tick; tick;
    chk_reset_vals("por");

    // reset asserted mid-REQ at addr 05
    rst = 1'b1; tick;
    pc = 8'h05; fetch_en = 1'b1;
    tick;
    chk("rq.req", 32'(bus.imem_req), 32'h1);
    chk("rq.addr", 32'(bus.imem_addr), 32'h05);
    #1 rst = 1'b0; fetch_en = 1'b0;
    #1 chk_reset_vals("midrst");
    rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hAAAA;
    tick; tick;
    chk("late_ack.irv", 32'(ir_valid), 32'h0);
    chk("late_ack.req", 32'(bus.imem_req), 32'h0);
    bus.imem_ack = 1'b0;

    // zero-wait fetch at pc 00 returning 1234
    pc = 8'h00; fetch_en = 1'b1; de_ready = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
    tick;
    chk("zw.E0.req", 32'(bus.imem_req), 32'h1);
    chk("zw.E0.addr", 32'(bus.imem_addr), 32'h00);
    tick;
    chk("zw.E1.ir", 32'(ir), 32'h1234);
    chk("zw.E1.ir_pc", 32'(ir_pc), 32'h00);
    chk("zw.E1.pp1", 32'(pc_plus_1), 32'h01);
    chk("zw.E1.step", 32'(pc_step), 32'h1);
    chk("zw.E1.irv", 32'(ir_valid), 32'h1);
    chk("zw.E1.req", 32'(bus.imem_req), 32'h0);
    pc = pc_plus_1;
    bus.imem_ack = 1'b0;
    tick;
    chk("zw.E2.req", 32'(bus.imem_req), 32'h1);
    chk("zw.E2.addr", 32'(bus.imem_addr), 32'h01);
    chk("zw.E2.step", 32'(pc_step), 32'h0);
    chk("zw.E2.irv", 32'(ir_valid), 32'h0);
    fetch_en = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5678;
    tick;
    chk("zw.E3.ir", 32'(ir), 32'h5678);
    chk("zw.E3.pp1", 32'(pc_plus_1), 32'h02);
    bus.imem_ack = 1'b0;
    tick;
    chk("zw.E4.irv", 32'(ir_valid), 32'h0);
    chk("zw.E4.req", 32'(bus.imem_req), 32'h0);

    // three wait cycles at addr 20; fetch_en drop must not cancel
    pc = 8'h20; fetch_en = 1'b1;
    tick;
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ws.addr", 32'(bus.imem_addr), 32'h20);
      chk("ws.req", 32'(bus.imem_req), 32'h1);
      chk("ws.irv", 32'(ir_valid), 32'h0);
      if (i == 3) begin
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hCAFE;
      end
      tick;
    end
    chk("ws.ir", 32'(ir), 32'hCAFE);
    chk("ws.irv1", 32'(ir_valid), 32'h1);
    chk("ws.step", 32'(pc_step), 32'h1);
    bus.imem_ack = 1'b0;
    tick;
    chk("ws.idle.irv", 32'(ir_valid), 32'h0);
    chk("ws.idle.step", 32'(pc_step), 32'h0);

    // branch while REQ at addr 10, late ack with DEAD is dropped
    pc = 8'h10; fetch_en = 1'b1;
    tick;
    br_taken = 1'b1;
    tick;
    chk("br.drop.req", 32'(bus.imem_req), 32'h1);
    chk("br.drop.irv", 32'(ir_valid), 32'h0);
    br_taken = 1'b0; pc = 8'h40;
    tick;
    chk("br.drop.addr", 32'(bus.imem_addr), 32'h10);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    tick;
    chk("br.ack.req", 32'(bus.imem_req), 32'h0);
    chk("br.ack.irv", 32'(ir_valid), 32'h0);
    chk("br.ack.step", 32'(pc_step), 32'h0);
    bus.imem_ack = 1'b0;
    tick;
    chk("br.new.addr", 32'(bus.imem_addr), 32'h40);
    chk("br.new.req", 32'(bus.imem_req), 32'h1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111;
    tick;
    chk("br.new.ir", 32'(ir), 32'h1111);
    chk("br.new.ir_pc", 32'(ir_pc), 32'h40);
    bus.imem_ack = 1'b0; fetch_en = 1'b0;
    tick;

    // decoder stall of 5 cycles holding BEEF
    pc = 8'h50; fetch_en = 1'b1; de_ready = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF;
    tick; tick;
    chk("st.ir", 32'(ir), 32'hBEEF);
    chk("st.step", 32'(pc_step), 32'h1);
    pc = pc_plus_1; bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("st.hold.ir", 32'(ir), 32'hBEEF);
      chk("st.hold.irv", 32'(ir_valid), 32'h1);
      chk("st.hold.req", 32'(bus.imem_req), 32'h0);
      chk("st.hold.step", 32'(pc_step), 32'h0);
    end
    de_ready = 1'b1;
    tick;
    chk("st.go.addr", 32'(bus.imem_addr), 32'h51);
    chk("st.go.req", 32'(bus.imem_req), 32'h1);
    chk("st.go.irv", 32'(ir_valid), 32'h0);

    // wrap at FF, then handoff colliding with a branch
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2222;
    tick;
    pc = 8'hFF; bus.imem_ack = 1'b0;
    tick;
    chk("wr.addr", 32'(bus.imem_addr), 32'hFF);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h3333;
    tick;
    chk("wr.ir_pc", 32'(ir_pc), 32'hFF);
    chk("wr.pp1", 32'(pc_plus_1), 32'h00);
    chk("wr.ir", 32'(ir), 32'h3333);
    bus.imem_ack = 1'b0; br_taken = 1'b1; pc = 8'h00;
    tick;
    chk("hb.irv", 32'(ir_valid), 32'h0);
    chk("hb.step", 32'(pc_step), 32'h0);
    chk("hb.req", 32'(bus.imem_req), 32'h0);
    br_taken = 1'b0;
    tick;
    chk("hb.next.req", 32'(bus.imem_req), 32'h1);

    // branch coincident with ack in REQ discards the data
    br_taken = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h4444;
    tick;
    chk("ba.req", 32'(bus.imem_req), 32'h0);
    chk("ba.irv", 32'(ir_valid), 32'h0);
    chk("ba.step", 32'(pc_step), 32'h0);
    br_taken = 1'b0; bus.imem_ack = 1'b0; fetch_en = 1'b0;
    tick;
    chk("ba.idle.irv", 32'(ir_valid), 32'h0);
    chk("ba.idle.ir", 32'(ir), 32'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
